// File: rtl/grf_hazard_ctrl.sv
// Hazard/forwarding controller: shadow E/M/W writer slots vs. D-stage operands.
// Optional mult/div interlock enabled by defining GRF_HAZARD_MD_INTERLOCK_EN.
module grf_hazard_ctrl #(
    parameter int TW = 2,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          d_valid,
    input  logic [AW-1:0] d_rs,
    input  logic [AW-1:0] d_rt,
    input  logic          d_rs_used,
    input  logic          d_rt_used,
    input  logic [TW-1:0] d_rs_tuse,
    input  logic [TW-1:0] d_rt_tuse,
    input  logic [AW-1:0] d_dst,
    input  logic [TW-1:0] d_tnew,
    input  logic          d_is_md,
    input  logic          d_md_start,
    input  logic          md_busy,
    output logic          stall,
    output logic [1:0]    fwd_d_rs,
    output logic [1:0]    fwd_d_rt,
    output logic [1:0]    fwd_e_rs,
    output logic [1:0]    fwd_e_rt
);

    function automatic logic [TW-1:0] sat_dec(input logic [TW-1:0] x);
        return (x == '0) ? '0 : x - 1'b1;
    endfunction

    function automatic logic hit(input logic vld, input logic [AW-1:0] dst,
                                 input logic [AW-1:0] a);
        return vld && (dst != '0) && (dst == a);
    endfunction

    logic          e_vld_p0, m_vld_p1, w_vld_p2;
    logic [AW-1:0] e_dst_p0, m_dst_p1, w_dst_p2;
    logic [TW-1:0] e_tnew_p0, m_tnew_p1, w_tnew_p2;
    logic [AW-1:0] e_rs_p0, e_rt_p0;
    logic          md_stall;

    // E slot: loads D, or a bubble while D is stalled
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            e_vld_p0  <= 1'b0;
            e_dst_p0  <= '0;
            e_tnew_p0 <= '0;
            e_rs_p0   <= '0;
            e_rt_p0   <= '0;
        end else if (stall) begin
            e_vld_p0  <= 1'b0;
            e_dst_p0  <= '0;
            e_tnew_p0 <= '0;
            e_rs_p0   <= '0;
            e_rt_p0   <= '0;
        end else begin
            e_vld_p0  <= d_valid;
            e_dst_p0  <= d_dst;
            e_tnew_p0 <= d_tnew;
            e_rs_p0   <= d_rs;
            e_rt_p0   <= d_rt;
        end
    end

    // M and W slots: always advance, counting down the remaining latency
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_vld_p1  <= 1'b0;
            m_dst_p1  <= '0;
            m_tnew_p1 <= '0;
            w_vld_p2  <= 1'b0;
            w_dst_p2  <= '0;
            w_tnew_p2 <= '0;
        end else begin
            m_vld_p1  <= e_vld_p0;
            m_dst_p1  <= e_dst_p0;
            m_tnew_p1 <= sat_dec(e_tnew_p0);
            w_vld_p2  <= m_vld_p1;
            w_dst_p2  <= m_dst_p1;
            w_tnew_p2 <= sat_dec(m_tnew_p1);
        end
    end

`ifdef GRF_HAZARD_MD_INTERLOCK_EN
    logic e_md_p0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            e_md_p0 <= 1'b0;
        end else if (stall) begin
            e_md_p0 <= 1'b0;
        end else begin
            e_md_p0 <= d_md_start;
        end
    end

    // md_busy lags the start by one cycle; the E-slot start bit covers that gap
    assign md_stall = d_is_md && (md_busy || (e_vld_p0 && e_md_p0));
`else
    logic unused_md;
    assign unused_md = d_is_md ^ d_md_start ^ md_busy;
    assign md_stall  = 1'b0;
`endif

    logic unused_w_tnew;
    assign unused_w_tnew = ^w_tnew_p2;

    logic e_hit_rs, e_hit_rt, m_hit_rs, m_hit_rt;
    logic raw_rs, raw_rt;
    logic m_hit_ers, m_hit_ert, w_hit_ers, w_hit_ert;

    assign e_hit_rs = hit(e_vld_p0, e_dst_p0, d_rs);
    assign e_hit_rt = hit(e_vld_p0, e_dst_p0, d_rt);
    assign m_hit_rs = hit(m_vld_p1, m_dst_p1, d_rs);
    assign m_hit_rt = hit(m_vld_p1, m_dst_p1, d_rt);

    // M tnew is already the remaining latency, so it compares directly against tuse
    assign raw_rs = d_rs_used && (e_hit_rs ? (e_tnew_p0 > d_rs_tuse)
                                           : (m_hit_rs && (m_tnew_p1 > d_rs_tuse)));
    assign raw_rt = d_rt_used && (e_hit_rt ? (e_tnew_p0 > d_rt_tuse)
                                           : (m_hit_rt && (m_tnew_p1 > d_rt_tuse)));

    assign stall = d_valid && (raw_rs || raw_rt || md_stall);

    assign fwd_d_rs = e_hit_rs ? ((e_tnew_p0 == '0) ? 2'd1 : 2'd0)
                    : (m_hit_rs && (m_tnew_p1 == '0)) ? 2'd2 : 2'd0;
    assign fwd_d_rt = e_hit_rt ? ((e_tnew_p0 == '0) ? 2'd1 : 2'd0)
                    : (m_hit_rt && (m_tnew_p1 == '0)) ? 2'd2 : 2'd0;

    assign m_hit_ers = hit(m_vld_p1, m_dst_p1, e_rs_p0);
    assign m_hit_ert = hit(m_vld_p1, m_dst_p1, e_rt_p0);
    assign w_hit_ers = hit(w_vld_p2, w_dst_p2, e_rs_p0);
    assign w_hit_ert = hit(w_vld_p2, w_dst_p2, e_rt_p0);

    assign fwd_e_rs = !e_vld_p0 ? 2'd0
                    : (m_hit_ers && (m_tnew_p1 == '0)) ? 2'd1
                    : w_hit_ers ? 2'd2 : 2'd0;
    assign fwd_e_rt = !e_vld_p0 ? 2'd0
                    : (m_hit_ert && (m_tnew_p1 == '0)) ? 2'd1
                    : w_hit_ert ? 2'd2 : 2'd0;

endmodule

// File: tb/tb_grf_hazard_ctrl.sv
// Directed bench for grf_hazard_ctrl; honours GRF_HAZARD_MD_INTERLOCK_EN for the MD section.
module tb_grf_hazard_ctrl;
    localparam int AW = 5;
    localparam int TW = 2;
`ifdef GRF_HAZARD_MD_INTERLOCK_EN
    localparam logic MD_ON = 1'b1;
`else
    localparam logic MD_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          d_valid, d_rs_used, d_rt_used, d_is_md, d_md_start, md_busy;
    logic [AW-1:0] d_rs, d_rt, d_dst;
    logic [TW-1:0] d_rs_tuse, d_rt_tuse, d_tnew;
    logic          stall;
    logic [1:0]    fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    grf_hazard_ctrl #(.TW(TW), .AW(AW)) dut (
        .clk(clk), .reset(reset), .d_valid(d_valid), .d_rs(d_rs), .d_rt(d_rt),
        .d_rs_used(d_rs_used), .d_rt_used(d_rt_used), .d_rs_tuse(d_rs_tuse),
        .d_rt_tuse(d_rt_tuse), .d_dst(d_dst), .d_tnew(d_tnew), .d_is_md(d_is_md),
        .d_md_start(d_md_start), .md_busy(md_busy), .stall(stall),
        .fwd_d_rs(fwd_d_rs), .fwd_d_rt(fwd_d_rt), .fwd_e_rs(fwd_e_rs), .fwd_e_rt(fwd_e_rt)
    );

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic s, input logic [1:0] drs,
                           input logic [1:0] drt, input logic [1:0] ers, input logic [1:0] ert);
        chk({tag, ".stall"},    {3'b0, stall}, {3'b0, s});
        chk({tag, ".fwd_d_rs"}, {2'b0, fwd_d_rs}, {2'b0, drs});
        chk({tag, ".fwd_d_rt"}, {2'b0, fwd_d_rt}, {2'b0, drt});
        chk({tag, ".fwd_e_rs"}, {2'b0, fwd_e_rs}, {2'b0, ers});
        chk({tag, ".fwd_e_rt"}, {2'b0, fwd_e_rt}, {2'b0, ert});
    endtask

    task automatic drive(input logic v, input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                         input logic rsu, input logic rtu, input logic [TW-1:0] rstu,
                         input logic [TW-1:0] rttu, input logic [AW-1:0] dst,
                         input logic [TW-1:0] tnew, input logic ismd, input logic mds);
        d_valid = v;      d_rs = rs;          d_rt = rt;
        d_rs_used = rsu;  d_rt_used = rtu;    d_rs_tuse = rstu;  d_rt_tuse = rttu;
        d_dst = dst;      d_tnew = tnew;      d_is_md = ismd;    d_md_start = mds;
    endtask

    task automatic idle();
        drive(1'b0, '0, '0, 1'b0, 1'b0, '0, '0, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset   = 1'b0;
        md_busy = 1'b0;
        drive(1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 2'd0, 2'd0, 5'd5, 2'd2, 1'b1, 1'b1);
        tick(); tick();
        @(negedge clk);
        chk_all("reset_held", 1'b0, 2'd0, 2'd0, 2'd0, 2'd0);

        idle();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            @(negedge clk);
            chk_all("post_reset_idle", 1'b0, 2'd0, 2'd0, 2'd0, 2'd0);
        end

        // Load-use: lw $5 then beq $5,$0
        tick();
        drive(1'b1, '0, '0, 1'b0, 1'b0, '0, '0, 5'd5, 2'd2, 1'b0, 1'b0);
        @(negedge clk);
        chk("lu_issue.stall", {3'b0, stall}, 4'd0);
        tick();
        drive(1'b1, 5'd5, 5'd0, 1'b1, 1'b1, 2'd0, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0);
        @(negedge clk);
        chk("lu_c1.stall", {3'b0, stall}, 4'd1);
        chk("lu_c1.fwd_d_rs", {2'b0, fwd_d_rs}, 4'd0);
        d_valid = 1'b0;
        #1 chk("lu_c1_novalid.stall", {3'b0, stall}, 4'd0);
        d_valid = 1'b1;
        d_rs_used = 1'b0;
        #1 chk("lu_c1_unused.stall", {3'b0, stall}, 4'd0);
        d_rs_used = 1'b1;
        tick();
        @(negedge clk);
        chk("lu_c2.stall", {3'b0, stall}, 4'd1);
        tick();
        @(negedge clk);
        chk("lu_c3.stall", {3'b0, stall}, 4'd0);
        chk("lu_c3.fwd_d_rs", {2'b0, fwd_d_rs}, 4'd0);
        tick(); idle(); tick(); tick(); tick();

        // ALU chain through E then M
        drive(1'b1, '0, '0, 1'b0, 1'b0, '0, '0, 5'd3, 2'd1, 1'b0, 1'b0);
        tick();
        drive(1'b1, 5'd3, 5'd0, 1'b1, 1'b0, 2'd1, 2'd0, 5'd4, 2'd1, 1'b0, 1'b0);
        @(negedge clk);
        chk_all("alu_d", 1'b0, 2'd0, 2'd0, 2'd0, 2'd0);
        tick();
        idle();
        @(negedge clk);
        chk_all("alu_e", 1'b0, 2'd0, 2'd0, 2'd1, 2'd0);
        tick();
        @(negedge clk);
        chk("alu_e_invalid.fwd_e_rs", {2'b0, fwd_e_rs}, 4'd0);

        // Producer two ahead: M forward in D, then W forward in E
        drive(1'b1, '0, '0, 1'b0, 1'b0, '0, '0, 5'd8, 2'd1, 1'b0, 1'b0);
        tick();
        drive(1'b1, '0, '0, 1'b0, 1'b0, '0, '0, 5'd0, 2'd0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 5'd0, 5'd8, 1'b0, 1'b1, 2'd0, 2'd1, 5'd0, 2'd0, 1'b0, 1'b0);
        @(negedge clk);
        chk_all("m_fwd_d", 1'b0, 2'd0, 2'd2, 2'd0, 2'd0);
        tick();
        idle();
        @(negedge clk);
        chk_all("w_fwd_e", 1'b0, 2'd0, 2'd0, 2'd0, 2'd2);
        tick(); tick(); tick();

        // $0 writer never stalls or forwards
        drive(1'b1, '0, '0, 1'b0, 1'b0, '0, '0, 5'd0, 2'd2, 1'b0, 1'b0);
        tick();
        drive(1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 2'd0, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0);
        @(negedge clk);
        chk_all("zero_reg", 1'b0, 2'd0, 2'd0, 2'd0, 2'd0);
        tick(); idle(); tick(); tick(); tick();

        // Youngest wins: addu $7 in M, lui $7 in E
        drive(1'b1, '0, '0, 1'b0, 1'b0, '0, '0, 5'd7, 2'd1, 1'b0, 1'b0);
        tick();
        drive(1'b1, '0, '0, 1'b0, 1'b0, '0, '0, 5'd7, 2'd0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 5'd0, 5'd7, 1'b0, 1'b1, 2'd0, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0);
        @(negedge clk);
        chk_all("youngest", 1'b0, 2'd0, 2'd1, 2'd0, 2'd0);
        tick(); idle(); tick(); tick(); tick();

        // Mult/div interlock
        drive(1'b1, '0, '0, 1'b0, 1'b0, '0, '0, '0, '0, 1'b1, 1'b1);
        @(negedge clk);
        chk("md_mult.stall", {3'b0, stall}, 4'd0);
        tick();
        drive(1'b1, '0, '0, 1'b0, 1'b0, '0, '0, 5'd2, 2'd1, 1'b1, 1'b0);
        @(negedge clk);
        chk("md_gap.stall", {3'b0, stall}, {3'b0, MD_ON});
        tick();
        md_busy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("md_busy.stall", {3'b0, stall}, {3'b0, MD_ON});
            tick();
        end
        md_busy = 1'b0;
        @(negedge clk);
        chk("md_done.stall", {3'b0, stall}, 4'd0);
        tick(); idle(); tick(); tick(); tick();

        // Reset asserted mid-stall clears everything immediately
        drive(1'b1, '0, '0, 1'b0, 1'b0, '0, '0, 5'd9, 2'd2, 1'b0, 1'b0);
        tick();
        drive(1'b1, 5'd9, 5'd0, 1'b1, 1'b0, 2'd0, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0);
        @(negedge clk);
        chk("midstall_pre.stall", {3'b0, stall}, 4'd1);
        #1 reset = 1'b0;
        #1 chk_all("midstall_reset", 1'b0, 2'd0, 2'd0, 2'd0, 2'd0);
        reset = 1'b1;
        tick();
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "timeout");
    end
endmodule
